alu_divn: RTL and testbench

ALU_DIVN -- requirements
Module: alu_divn

---
 rtl/alu_pkg.sv | 12 +
 rtl/alu_divn_step.sv | 24 ++
 rtl/alu_divn.sv | 128 ++++++++++++
 tb/tb_alu_divn.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared divider state type and width limit
package alu_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CALC   = 2'd1,
    FINISH = 2'd2
  } divn_state_t;

  localparam int DIVN_W_MAX = 32;

endpackage

// File: rtl/alu_divn_step.sv
// rtl/alu_divn_step.sv - one combinational restoring-division step
module alu_divn_step #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] part_in,
  input  logic [WIDTH-1:0] quo_in,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] part_out,
  output logic [WIDTH-1:0] quo_out
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;
  logic           keep;

  // The stored remainder is always below |b| <= 2^(WIDTH-1), so the shifted
  // value fits WIDTH+1 bits and diff's MSB is a clean sign bit.
  assign shifted  = {part_in, quo_in[WIDTH-1]};
  assign diff     = shifted - {1'b0, divisor};
  assign keep     = ~diff[WIDTH];
  assign part_out = keep ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
  assign quo_out  = {quo_in[WIDTH-2:0], keep};

endmodule

// File: rtl/alu_divn.sv
// rtl/alu_divn.sv - signed multi-cycle restoring divider; ALU_DIVN_REMAINDER_EN enables the remainder output
module alu_divn
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic             overflow
);

  localparam int CW = $clog2(DIVN_W_MAX + 1);
  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

  divn_state_t      state;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] part;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] dvs;
  logic             sign_a;
  logic             sign_b;
  logic             zero_b;
  logic             ovf_op;

  logic [WIDTH-1:0] part_next;
  logic [WIDTH-1:0] quo_next;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [WIDTH-1:0] q_fix;

  assign a_mag = a[WIDTH-1] ? -a : a;
  assign b_mag = b[WIDTH-1] ? -b : b;
  assign q_fix = (sign_a ^ sign_b) ? -quo : quo;

  alu_divn_step #(.WIDTH(WIDTH)) u_step (
    .part_in  (part),
    .quo_in   (quo),
    .divisor  (dvs),
    .part_out (part_next),
    .quo_out  (quo_next)
  );

`ifdef ALU_DIVN_REMAINDER_EN
  logic [WIDTH-1:0] r_mag;
  logic [WIDTH-1:0] r_fix;

  // With a zero divisor the shift register still holds |a| untouched.
  assign r_mag = zero_b ? quo : part;
  assign r_fix = sign_a ? -r_mag : r_mag;
`else
  assign remainder = '0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      count       <= '0;
      part        <= '0;
      quo         <= '0;
      dvs         <= '0;
      sign_a      <= 1'b0;
      sign_b      <= 1'b0;
      zero_b      <= 1'b0;
      ovf_op      <= 1'b0;
      quotient    <= '0;
`ifdef ALU_DIVN_REMAINDER_EN
      remainder   <= '0;
`endif
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start && !abort) begin
            part   <= '0;
            count  <= '0;
            quo    <= a_mag;
            dvs    <= b_mag;
            sign_a <= a[WIDTH-1];
            sign_b <= b[WIDTH-1];
            zero_b <= (b == '0);
            ovf_op <= (a == MIN_VAL) && (b == '1);
            busy   <= 1'b1;
            state  <= (b == '0) ? FINISH : CALC;
          end
        end
        CALC: begin
          if (abort) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            part  <= part_next;
            quo   <= quo_next;
            count <= count + 1'b1;
            if (count == CW'(WIDTH - 1)) state <= FINISH;
          end
        end
        FINISH: begin
          if (!abort) begin
            quotient    <= zero_b ? '0 : q_fix;
`ifdef ALU_DIVN_REMAINDER_EN
            remainder   <= r_fix;
`endif
            div_by_zero <= zero_b;
            overflow    <= ovf_op;
            done        <= 1'b1;
          end
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_divn.sv
// tb/tb_alu_divn.sv - self-checking bench for alu_divn at WIDTH 8 and 16
module tb_alu_divn;

  logic clk = 1'b0;
  logic reset_n = 1'b0;

  logic [7:0]  a8 = '0, b8 = '0, q8, r8;
  logic        start8 = 1'b0, abort8 = 1'b0, busy8, done8, dz8, ov8;
  logic [15:0] a16 = '0, b16 = '0, q16, r16;
  logic        start16 = 1'b0, abort16 = 1'b0, busy16, done16, dz16, ov16;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_divn #(.WIDTH(8)) dut8 (
    .clk(clk), .reset_n(reset_n), .start(start8), .abort(abort8), .a(a8), .b(b8),
    .quotient(q8), .remainder(r8), .busy(busy8), .done(done8),
    .div_by_zero(dz8), .overflow(ov8)
  );

  alu_divn #(.WIDTH(16)) dut16 (
    .clk(clk), .reset_n(reset_n), .start(start16), .abort(abort16), .a(a16), .b(b16),
    .quotient(q16), .remainder(r16), .busy(busy16), .done(done16),
    .div_by_zero(dz16), .overflow(ov16)
  );

  typedef struct {
    int     w;
    longint a;
    longint b;
    longint q;
    longint r;
    bit     dz;
    bit     ov;
    int     lat;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic longint rem_exp(input longint r);
`ifdef ALU_DIVN_REMAINDER_EN
    return r;
`else
    return 0;
`endif
  endfunction

  // Reference: SV integer division truncates toward zero and % follows the dividend.
  function automatic void model(input int w, input longint av, input longint bv,
                                output longint q, output longint r,
                                output bit dz, output bit ov, output int lat);
    longint mn = -(64'sd1 <<< (w - 1));
    dz = 0; ov = 0; lat = w + 1;
    if (bv == 0) begin
      q = 0; r = av; dz = 1; lat = 1;
    end else if (av == mn && bv == -1) begin
      q = mn; r = 0; ov = 1;
    end else begin
      q = av / bv; r = av % bv;
    end
    r = rem_exp(r);
  endfunction

  function automatic longint rnd_signed(input int w);
    longint x = longint'($urandom) & ((64'sd1 <<< w) - 1);
    if (x >= (64'sd1 <<< (w - 1))) x -= (64'sd1 <<< w);
    return x;
  endfunction

  function automatic longint sq(input int w);
    return (w == 8) ? longint'($signed(q8)) : longint'($signed(q16));
  endfunction

  function automatic longint sr(input int w);
    return (w == 8) ? longint'($signed(r8)) : longint'($signed(r16));
  endfunction

  function automatic logic dn(input int w);
    return (w == 8) ? done8 : done16;
  endfunction

  function automatic logic bz(input int w);
    return (w == 8) ? busy8 : busy16;
  endfunction

  task automatic do_op(input int w, input longint av, input longint bv, output int lat);
    @(negedge clk);
    if (w == 8) begin a8 = av[7:0]; b8 = bv[7:0]; start8 = 1'b1; end
    else begin a16 = av[15:0]; b16 = bv[15:0]; start16 = 1'b1; end
    @(posedge clk);
    @(negedge clk);
    start8 = 1'b0; start16 = 1'b0;
    check("busy_after_e0", bz(w), 1);
    lat = -1;
    for (int k = 1; k <= 60; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (dn(w)) begin lat = k; break; end
    end
    @(posedge clk);
    @(negedge clk);
    check("done_one_cycle", dn(w), 0);
    check("busy_after_done", bz(w), 0);
  endtask

  task automatic run_and_check(input int w, input longint av, input longint bv,
                               input longint eq, input longint er,
                               input bit edz, input bit eov, input int elat);
    int   lat;
    logic fdz, fov;
    do_op(w, av, bv, lat);
    fdz = (w == 8) ? dz8 : dz16;
    fov = (w == 8) ? ov8 : ov16;
    check("latency", lat, elat);
    check("quotient", sq(w), eq);
    check("remainder", sr(w), er);
    check("div_by_zero", fdz, edz);
    check("overflow", fov, eov);
  endtask

  initial begin
    int     lat, ndone, guard;
    longint eq, er, av, bv;
    bit     edz, eov;
    int     elat;

    vecs.push_back('{8,  100,   7,   14,   2, 0, 0, 9});
    vecs.push_back('{8, -100,   7,  -14,  -2, 0, 0, 9});
    vecs.push_back('{8,  100,  -7,  -14,   2, 0, 0, 9});
    vecs.push_back('{8,    5,   0,    0,   5, 1, 0, 1});
    vecs.push_back('{8, -128,  -1, -128,   0, 0, 1, 9});
    vecs.push_back('{8, -128,   0,    0, -128, 1, 0, 1});
    vecs.push_back('{8,  127, -128,   0, 127, 0, 0, 9});
    vecs.push_back('{8, -128,   1, -128,   0, 0, 0, 9});
    vecs.push_back('{16, 30000, -7, -4285, 5, 0, 0, 17});

    // Reset values
    #12;
    check("rst_q8", q8, 0);
    check("rst_r8", r8, 0);
    check("rst_busy8", busy8, 0);
    check("rst_done8", done8, 0);
    check("rst_flags8", {dz8, ov8}, 0);
    check("rst_q16", q16, 0);
    check("rst_busy16", busy16, 0);
    @(negedge clk);
    reset_n = 1'b1;

    foreach (vecs[i])
      run_and_check(vecs[i].w, vecs[i].a, vecs[i].b, vecs[i].q, rem_exp(vecs[i].r),
                    vecs[i].dz, vecs[i].ov, vecs[i].lat);

    // Randomized against the reference model, with forced corner picks
    for (int i = 0; i < 40; i++) begin
      int w = (i % 4 == 3) ? 16 : 8;
      av = rnd_signed(w);
      bv = rnd_signed(w);
      if ($urandom_range(0, 9) == 0) bv = 0;
      if ($urandom_range(0, 9) == 0) begin av = -(64'sd1 <<< (w - 1)); bv = -1; end
      model(w, av, bv, eq, er, edz, eov, elat);
      run_and_check(w, av, bv, eq, er, edz, eov, elat);
    end

    // Establish known results before the multi-cycle corner cases
    run_and_check(8, 100, 7, 14, rem_exp(2), 0, 0, 9);

    // start held for 12 cycles: only one result lands inside the window
    @(negedge clk);
    a8 = 8'd60; b8 = 8'd9; start8 = 1'b1;
    ndone = 0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (done8) ndone++;
      if (k == 5) begin a8 = 8'd1; b8 = 8'd1; end
    end
    start8 = 1'b0;
    check("held_start_dones", ndone, 1);
    check("held_start_q", sq(8), 6);
    check("held_start_r", sr(8), rem_exp(6));
    guard = 0;
    while (busy8 && guard < 40) begin @(posedge clk); @(negedge clk); guard++; end
    check("held_start_drain", busy8, 0);
    run_and_check(8, 100, 7, 14, rem_exp(2), 0, 0, 9);

    // Abort mid-calculation
    @(negedge clk);
    a8 = 8'd50; b8 = 8'd3; start8 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start8 = 1'b0;
    for (int k = 1; k <= 4; k++) begin @(posedge clk); @(negedge clk); end
    abort8 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    abort8 = 1'b0;
    check("abort_busy", busy8, 0);
    ndone = 0;
    for (int k = 0; k < 15; k++) begin
      @(posedge clk); @(negedge clk);
      if (done8) ndone++;
    end
    check("abort_no_done", ndone, 0);
    check("abort_q_held", sq(8), 14);
    check("abort_r_held", sr(8), rem_exp(2));

    // Asynchronous reset during CALC
    @(negedge clk);
    a8 = 8'd77; b8 = 8'd5; start8 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start8 = 1'b0;
    @(posedge clk); @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    check("arst_q", q8, 0);
    check("arst_r", r8, 0);
    check("arst_busy", busy8, 0);
    check("arst_done", done8, 0);
    check("arst_flags", {dz8, ov8}, 0);
    @(negedge clk);
    reset_n = 1'b1;
    ndone = 0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); @(negedge clk);
      if (done8 || busy8) ndone++;
    end
    check("arst_no_done", ndone, 0);
    run_and_check(8, -77, 5, -15, rem_exp(-2), 0, 0, 9);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
